// File: rtl/vc_bit_scan_iterator.sv
// Set-bit iterator: accepts a mask and streams the index of each set bit, one per beat, tagging the last.
// Optional macro VC_BIT_SCAN_ITERATOR_BYPASS_EN accepts the next mask on the final beat (no idle bubble).
module vc_bit_scan_iterator #(
  parameter int p_nbits     = 32,
  parameter bit p_msb_first = 1'b0
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       in_val,
  output logic                       in_rdy,
  input  logic [p_nbits-1:0]         in_msg,
  output logic                       out_val,
  input  logic                       out_rdy,
  output logic [$clog2(p_nbits)-1:0] out_idx,
  output logic                       out_last
);
  localparam int p_nbits_idx = $clog2(p_nbits);
  localparam logic [p_nbits-1:0] ONE = p_nbits'(1);

  typedef enum logic {IDLE, SCAN} state_t;

  state_t                 state, state_nxt;
  logic [p_nbits-1:0]     rem, rem_nxt;
  logic [p_nbits_idx-1:0] enc_idx;
  logic                   enc_single;
  logic                   in_xfer, out_xfer;

  assign in_xfer  = in_val & in_rdy;
  assign out_xfer = out_val & out_rdy;

  // Last match in loop order wins: ascending scan finds the highest bit, descending the lowest.
  always_comb begin
    enc_idx = '0;
    if (p_msb_first) begin
      for (int i = 0; i < p_nbits; i++)
        if (rem[i]) enc_idx = p_nbits_idx'(i);
    end else begin
      for (int i = p_nbits - 1; i >= 0; i--)
        if (rem[i]) enc_idx = p_nbits_idx'(i);
    end
  end

  assign enc_single = (rem != '0) && ((rem & (rem - ONE)) == '0);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= IDLE;
      rem   <= '0;
    end else begin
      state <= state_nxt;
      rem   <= rem_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    rem_nxt   = rem;
    case (state)
      IDLE: begin
        // A zero mask is consumed here and simply dropped.
        if (in_xfer && in_msg != '0) begin
          state_nxt = SCAN;
          rem_nxt   = in_msg;
        end
      end
      SCAN: begin
        if (out_xfer) begin
          rem_nxt = rem & ~(ONE << enc_idx);
          if (enc_single) begin
            state_nxt = IDLE;
`ifdef VC_BIT_SCAN_ITERATOR_BYPASS_EN
            if (in_xfer && in_msg != '0) begin
              state_nxt = SCAN;
              rem_nxt   = in_msg;
            end
`endif
          end
        end
      end
      default: begin
        state_nxt = IDLE;
        rem_nxt   = '0;
      end
    endcase
  end

  // in_rdy is held low while reset is asserted, then rises in IDLE.
  always_comb begin
    in_rdy   = 1'b0;
    out_val  = 1'b0;
    out_idx  = '0;
    out_last = 1'b0;
    case (state)
      IDLE: in_rdy = ~reset;
      SCAN: begin
        out_val  = 1'b1;
        out_idx  = enc_idx;
        out_last = enc_single;
`ifdef VC_BIT_SCAN_ITERATOR_BYPASS_EN
        in_rdy   = out_rdy & enc_single;
`endif
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_vc_bit_scan_iterator.sv
// Bench for vc_bit_scan_iterator: an LSB-first and an MSB-first instance share stimulus and are checked against index lists.
module tb_vc_bit_scan_iterator;
`ifdef VC_BIT_SCAN_ITERATOR_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        in_val = 1'b0;
  logic [31:0] in_msg = '0;
  logic        out_rdy = 1'b1;
  logic        in_rdy0, in_rdy1, out_val0, out_val1, out_last0, out_last1;
  logic [4:0]  out_idx0, out_idx1;
  int          total = 0;
  int          bad = 0;

  always #5 clk = ~clk;

  vc_bit_scan_iterator #(.p_nbits(32), .p_msb_first(1'b0)) dut_lo (
    .clk(clk), .reset(reset), .in_val(in_val), .in_rdy(in_rdy0), .in_msg(in_msg),
    .out_val(out_val0), .out_rdy(out_rdy), .out_idx(out_idx0), .out_last(out_last0));

  vc_bit_scan_iterator #(.p_nbits(32), .p_msb_first(1'b1)) dut_hi (
    .clk(clk), .reset(reset), .in_val(in_val), .in_rdy(in_rdy1), .in_msg(in_msg),
    .out_val(out_val1), .out_rdy(out_rdy), .out_idx(out_idx1), .out_last(out_last1));

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Offers mask m, then walks every expected beat; out_rdy is low for hold cycles, then random per stall_pct.
  task automatic run_mask(input logic [31:0] m, input int hold, input int stall_pct);
    int lo[$];
    int hi[$];
    int k, budget, h;
    for (int i = 0; i < 32; i++) if (m[i]) lo.push_back(i);
    for (int i = 31; i >= 0; i--) if (m[i]) hi.push_back(i);
    in_val = 1'b1;
    in_msg = m;
    budget = 0;
    while (!in_rdy0 && budget < 50) begin step(); budget++; end
    chk("accept_timeout", 32'(budget < 50), 32'd1);
    step();
    in_val = 1'b0;
    in_msg = $urandom;
    k = 0;
    h = hold;
    budget = 0;
    while (k < lo.size() && budget < 1000) begin
      out_rdy = (h > 0) ? 1'b0 : ($urandom_range(0, 99) >= stall_pct);
      if (h > 0) h--;
      chk("val_lo", 32'(out_val0), 32'd1);
      chk("val_hi", 32'(out_val1), 32'd1);
      chk("idx_lo", 32'(out_idx0), 32'(lo[k]));
      chk("idx_hi", 32'(out_idx1), 32'(hi[k]));
      chk("last_lo", 32'(out_last0), 32'(k == lo.size() - 1));
      chk("last_hi", 32'(out_last1), 32'(k == hi.size() - 1));
      chk("rdy_scan", 32'(in_rdy0), 32'(BYP && out_rdy && (k == lo.size() - 1)));
      step();
      if (out_rdy) k++;
      budget++;
    end
    chk("beat_timeout", 32'(budget < 1000), 32'd1);
    out_rdy = 1'b1;
    chk("idle_val", 32'(out_val0 | out_val1), 32'd0);
    chk("idle_rdy", 32'(in_rdy0 & in_rdy1), 32'd1);
    chk("idle_idx", 32'(out_idx0) | 32'(out_idx1) | 32'(out_last0), 32'd0);
  endtask

  initial begin
    // reset state
    reset = 1'b1;
    #12;
    chk("rst_rdy", 32'(in_rdy0 | in_rdy1), 32'd0);
    chk("rst_val", 32'(out_val0 | out_val1), 32'd0);
    chk("rst_idx", 32'(out_idx0) | 32'(out_last0), 32'd0);
    step();
    reset = 1'b0;
    #1;
    chk("post_rst_rdy", 32'(in_rdy0), 32'd1);

    // zero mask is swallowed, test-plan masks, stall, boundaries
    run_mask(32'h0000_0000, 0, 0);
    run_mask(32'h8000_0021, 0, 0);
    run_mask(32'h0000_0300, 3, 0);
    run_mask(32'h8000_0000, 0, 0);
    run_mask(32'h0000_0001, 0, 0);
    run_mask(32'hFFFF_FFFF, 0, 0);

    // random masks with random backpressure
    for (int n = 0; n < 25; n++) begin
      logic [31:0] m;
      m = $urandom;
      if (n % 3 == 1) m = m & $urandom & $urandom;
      if (n % 7 == 5) m = 32'h0;
      run_mask(m, 0, 40);
    end

    // reset in the middle of an all-ones scan
    out_rdy = 1'b1;
    in_val = 1'b1;
    in_msg = 32'hFFFF_FFFF;
    step();
    in_val = 1'b0;
    for (int b = 0; b < 4; b++) begin
      chk("rst_scan_idx_lo", 32'(out_idx0), 32'(b));
      chk("rst_scan_idx_hi", 32'(out_idx1), 32'(31 - b));
      step();
    end
    chk("rst_scan_val_pre", 32'(out_val0), 32'd1);
    #2;
    reset = 1'b1;
    #1;
    chk("rst_scan_val_drop", 32'(out_val0 | out_val1), 32'd0);
    chk("rst_scan_rdy", 32'(in_rdy0), 32'd0);
    step();
    reset = 1'b0;
    #1;
    chk("rst_scan_rdy_after", 32'(in_rdy0), 32'd1);
    step();
    chk("rst_scan_no_more", 32'(out_val0 | out_val1), 32'd0);

    // back-to-back masks 3 then 4, upstream holding in_val
    in_val = 1'b1;
    in_msg = 32'h3;
    step();
    in_msg = 32'h4;
    chk("b2b_idx0", 32'(out_idx0), 32'd0);
    chk("b2b_last0", 32'(out_last0), 32'd0);
    chk("b2b_rdy0", 32'(in_rdy0), 32'd0);
    step();
    chk("b2b_idx1", 32'(out_idx0), 32'd1);
    chk("b2b_last1", 32'(out_last0), 32'd1);
    chk("b2b_rdy1", 32'(in_rdy0), 32'(BYP));
    if (!BYP) begin
      step();
      chk("b2b_bubble_val", 32'(out_val0), 32'd0);
      chk("b2b_bubble_rdy", 32'(in_rdy0), 32'd1);
    end
    step();
    in_val = 1'b0;
    chk("b2b_val2", 32'(out_val0), 32'd1);
    chk("b2b_idx2", 32'(out_idx0), 32'd2);
    chk("b2b_idx2_hi", 32'(out_idx1), 32'd2);
    chk("b2b_last2", 32'(out_last0 & out_last1), 32'd1);
    step();
    chk("b2b_done", 32'(out_val0), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/vc_bit_scan_iterator.md
Name: vc_bit_scan_iterator

Overview:
- Sequential companion to the priority encoders, sitting directly upstream of the consumer of set-bit indices.
- Accepts one p_nbits-wide mask per val/rdy transaction.
- Emits, one per cycle, the index of every set bit in the mask as a stream of val/rdy messages, tagging the final index.
- Typical uses: walking a ready/valid vector, a free-list bitmap or a writeback mask.

Parameters:
- p_nbits, 32, mask width; power of two, 2..32.
- p_nbits_idx, $clog2(p_nbits), index width; derived, never overridden.
- p_msb_first, 0, emission order. 0 = lowest set bit first (reverse-priority order). 1 = highest set bit first (priority order).

Ports:
- clk  input  1  clock; all state updates on posedge.
- reset  input  1  asynchronous, active-high reset.
- in_val  input  1  mask message valid.
- in_rdy  output  1  block can accept a mask.
- in_msg  input  p_nbits  mask to scan.
- out_val  output  1  index message valid.
- out_rdy  input  1  downstream accepts index.
- out_idx  output  p_nbits_idx  index of the current set bit.
- out_last  output  1  current index is the final set bit of this mask.

Behaviour:
- Clock and reset: one clock, clk. reset is asynchronous, active-high: assertion clears state immediately, without waiting for a clock edge.
- State: FSM {IDLE, SCAN}; remaining-mask register rem[p_nbits-1:0].
- While reset is high: state = IDLE, rem = 0, in_rdy = 0, out_val = 0, out_idx = 0, out_last = 0.
- After reset deasserts: in_rdy = 1.
- IDLE:
  - in_rdy = 1, out_val = 0, out_idx = 0, out_last = 0.
  - Transfer on in_val & in_rdy at a posedge.
  - Nonzero in_msg: rem <= in_msg, go to SCAN.
  - Zero in_msg: consumed and discarded, stays IDLE, produces no output.
- SCAN:
  - in_rdy = 0, out_val = 1.
  - out_idx = position of the lowest set bit of rem (p_msb_first = 0) or the highest set bit (p_msb_first = 1), computed combinationally from rem.
  - out_last = 1 iff rem has exactly one bit set.
  - On out_val & out_rdy: clear that bit in rem. If out_last, go to IDLE; otherwise stay in SCAN.
  - out_rdy low: outputs hold stable, no state change.
- Latency and throughput:
  - First index is valid the cycle after the input transfer.
  - One index per cycle while out_rdy is high.
  - A mask with k set bits occupies SCAN for exactly k accepted beats.
  - Without the optional feature, one idle cycle (in_rdy = 1, out_val = 0) separates consecutive masks.
- Boundaries:
  - in_msg all ones: p_nbits beats, indices 0..p_nbits-1 (or descending when p_msb_first = 1); out_last only on the final beat.
  - Single bit at position p_nbits-1: one beat, out_last = 1.
  - Reset asserted during SCAN: out_val drops immediately, rem is lost, remaining indices are never emitted.
  - in_val asserted while in SCAN: ignored (in_rdy = 0); the upstream holds the message.
- Outputs are combinational from registered state only. No combinational path from in_* to out_*, or from out_rdy to in_rdy, except as described under Optional Feature.

Optional Feature:
- Macro: VC_BIT_SCAN_ITERATOR_BYPASS_EN.
- Defined:
  - In SCAN, in_rdy = out_rdy & out_last. A new mask transfers on the same edge as the final index of the current mask.
  - Nonzero new mask: rem <= new mask, remain in SCAN.
  - Zero new mask: go to IDLE.
  - Result: back-to-back masks with no bubble. This adds a combinational path from out_rdy to in_rdy.
- Undefined: behaviour exactly as in Behaviour, with a one-cycle IDLE bubble between masks.

Test Plan:
- Reset, then in_msg = 32'h0000_0000 with in_val = 1 for one cycle -> transfer accepted, out_val stays 0, in_rdy remains 1.
- in_msg = 32'h8000_0021, out_rdy = 1, p_msb_first = 0 -> out_idx 0, 5, 31 on consecutive cycles; out_last = 1 only on 31; then IDLE.
- Same mask with p_msb_first = 1 -> out_idx 31, 5, 0; out_last on 0.
- in_msg = 32'h0000_0300, out_rdy low for 3 cycles then high -> out_idx holds at 8 with out_val = 1 during the stall, then emits 8, 9.
- in_msg = 32'hFFFF_FFFF, reset asserted mid-cycle after 4 beats -> out_val falls before the next edge; no further indices; in_rdy = 1 after deassertion.
- Masks 32'h3 then 32'h4 offered back-to-back -> without the macro: 0, 1, bubble, 2; with VC_BIT_SCAN_ITERATOR_BYPASS_EN: 0, 1, 2 with no bubble.
